// File: rtl/sqrt_sum_pipe_pkg.sv
// -----------------------------------------------------------------------------
// sqrt_sum_pipe_pkg
// Shared sizing helpers for the root-sum pipeline: result width, end-to-end
// latency, adder-tree depth and the number of nodes on each tree level.
// Also carries the default-configuration sizes as localparams.
// Optional feature macro used elsewhere in the slice: SQRT_SUM_PIPE_EXACT_EN.
// -----------------------------------------------------------------------------
package sqrt_sum_pipe_pkg;

    // Ceiling log2, with clog2_f(1) == 0 so a single channel needs no tree.
    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        while ((32'sd1 <<< r) < n) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

    // Number of registered adder-tree levels.
    function automatic int tree_levels_f(input int n_ch);
        return clog2_f(n_ch);
    endfunction

    // Nodes on tree level lvl (level 0 = masked leaves): ceil(n_ch / 2^lvl).
    function automatic int level_nodes_f(input int n_ch, input int lvl);
        return (n_ch + (32'sd1 <<< lvl) - 32'sd1) >>> lvl;
    endfunction

    // Result width: one root is ARG_W/2 bits, each tree level adds one bit.
    function automatic int res_w_f(input int n_ch, input int arg_w);
        return (arg_w / 32'sd2) + clog2_f(n_ch);
    endfunction

    // Register stages from argument capture to result: root digits,
    // tree levels and the output register.
    function automatic int lat_f(input int n_ch, input int arg_w);
        return (arg_w / 32'sd2) + clog2_f(n_ch) + 32'sd1;
    endfunction

    localparam int DEF_N_CH       = 3;
    localparam int DEF_ARG_W      = 32;
    localparam int DEF_TAG_W      = 4;
    localparam int DEF_RES_W      = res_w_f(DEF_N_CH, DEF_ARG_W);
    localparam int DEF_LAT        = lat_f(DEF_N_CH, DEF_ARG_W);
    localparam int DEF_TREE_LEVELS = tree_levels_f(DEF_N_CH);
    localparam int DEF_LEAF_NODES = level_nodes_f(DEF_N_CH, 0);
    localparam int DEF_ROOT_NODES = level_nodes_f(DEF_N_CH, DEF_TREE_LEVELS);

endpackage

// File: rtl/sqrt_sum_pipe_if.sv
// -----------------------------------------------------------------------------
// sqrt_sum_pipe_if
// Argument/result bundle of the root-sum pipeline.
//   master : drives arg_vld, arg, ch_en, arg_tag; observes the result side
//   slave  : the pipeline; drives res_vld, res, res_tag (and res_exact)
// Signals
//   arg_vld  one argument set per asserted cycle, no backpressure
//   arg      N_CH*ARG_W, channel i at [i*ARG_W +: ARG_W], unsigned
//   ch_en    per-transaction channel enable mask
//   arg_tag  opaque tag returned with the result
//   res_vld  single-cycle result strobe
//   res      RES_W sum of floor(sqrt()) over enabled channels
//   res_tag  tag of the transaction producing res
//   res_exact (only with SQRT_SUM_PIPE_EXACT_EN) every enabled arg a square
// -----------------------------------------------------------------------------
interface sqrt_sum_pipe_if
    import sqrt_sum_pipe_pkg::*;
#(
    parameter int N_CH  = 3,
    parameter int ARG_W = 32,
    parameter int TAG_W = 4
);
    localparam int RES_W = res_w_f(N_CH, ARG_W);

    logic                  arg_vld;
    logic [N_CH*ARG_W-1:0] arg;
    logic [N_CH-1:0]       ch_en;
    logic [TAG_W-1:0]      arg_tag;
    logic                  res_vld;
    logic [RES_W-1:0]      res;
    logic [TAG_W-1:0]      res_tag;
`ifdef SQRT_SUM_PIPE_EXACT_EN
    logic                  res_exact;
`endif

    modport master (
        output arg_vld,
        output arg,
        output ch_en,
        output arg_tag,
        input  res_vld,
        input  res,
        input  res_tag
`ifdef SQRT_SUM_PIPE_EXACT_EN
        ,
        input  res_exact
`endif
    );

    modport slave (
        input  arg_vld,
        input  arg,
        input  ch_en,
        input  arg_tag,
        output res_vld,
        output res,
        output res_tag
`ifdef SQRT_SUM_PIPE_EXACT_EN
        ,
        output res_exact
`endif
    );

endinterface

// File: rtl/sqrt_sum_pipe_isqrt_pipe_w.sv
// -----------------------------------------------------------------------------
// isqrt_pipe_w
// Pipelined integer square root, y = floor(sqrt(x)), restoring digit-by-digit:
// one root bit per stage, ARG_W/2 stages. Each stage has its own valid bit;
// data registers only move under that valid, so an idle channel never toggles.
// Ports
//   clk, rst  clock, synchronous active-low reset (clears valid bits only)
//   x_vld, x  operand strobe and ARG_W-bit unsigned operand
//   y_vld, y  result strobe and ARG_W/2-bit root, ARG_W/2 cycles later
//   y_exact   (only with SQRT_SUM_PIPE_EXACT_EN) final remainder was zero
// -----------------------------------------------------------------------------
module isqrt_pipe_w #(
    parameter int ARG_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x_vld,
    input  logic [ARG_W-1:0]   x,
    output logic               y_vld,
    output logic [ARG_W/2-1:0] y
`ifdef SQRT_SUM_PIPE_EXACT_EN
    ,
    output logic               y_exact
`endif
);
    localparam int HALF  = ARG_W / 2;
    localparam int REM_W = HALF + 2;

    for (genvar s = 0; s < HALF; s++) begin : g_stage
        logic             vld_in_s;
        logic [ARG_W-1:0] x_in_s;
        logic [HALF-1:0]  q_in_s;
        logic [REM_W-1:0] rem_in_s;
        logic [REM_W-1:0] cand_s;
        logic [REM_W-1:0] trial_s;
        logic [REM_W:0]   diff_s;
        logic             take_s;
        logic [REM_W-1:0] rem_nxt_s;
        logic [HALF-1:0]  q_nxt_s;
        logic             vld_r;
        logic [HALF-1:0]  q_r;
        logic             spare_unused_s;

        if (s == 0) begin : g_src
            assign vld_in_s = x_vld;
            assign x_in_s   = x;
            assign q_in_s   = '0;
            assign rem_in_s = '0;
        end else begin : g_src
            assign vld_in_s = g_stage[s-1].vld_r;
            assign x_in_s   = g_stage[s-1].g_keep.x_r;
            assign q_in_s   = g_stage[s-1].q_r;
            assign rem_in_s = g_stage[s-1].g_keep.rem_r;
        end

        // One root digit: bring down the next two operand bits and try 4q+1.
        // The incoming remainder is at most 2q < 2^HALF and q has at most s
        // bits, so the dropped top bits are always zero.
        always_comb begin
            cand_s  = {rem_in_s[HALF-1:0], x_in_s[ARG_W-1 -: 2]};
            trial_s = {q_in_s, 2'b01};
            diff_s  = {1'b0, cand_s} - {1'b0, trial_s};
            take_s  = ~diff_s[REM_W];
            if (take_s) begin
                rem_nxt_s = diff_s[REM_W-1:0];
            end else begin
                rem_nxt_s = cand_s;
            end
            q_nxt_s = {q_in_s[HALF-2:0], take_s};
        end

        // Stage valid; the only state reset clears.
        always_ff @(posedge clk) begin
            if (!rst) begin
                vld_r <= 1'b0;
            end else begin
                vld_r <= vld_in_s;
            end
        end

        // Partial root, advanced only when this stage holds a transaction.
        always_ff @(posedge clk) begin
            if (vld_in_s) begin
                q_r <= q_nxt_s;
            end
        end

        if (s < HALF - 1) begin : g_keep
            logic [ARG_W-1:0] x_r;
            logic [REM_W-1:0] rem_r;

            // Operand bits still to consume and the running remainder.
            always_ff @(posedge clk) begin
                if (vld_in_s) begin
                    x_r   <= {x_in_s[ARG_W-3:0], 2'b00};
                    rem_r <= rem_nxt_s;
                end
            end

            assign spare_unused_s = ^{rem_in_s[REM_W-1 -: 2], q_in_s[HALF-1]};
        end else begin : g_last
`ifdef SQRT_SUM_PIPE_EXACT_EN
            logic exact_r;

            // A zero final remainder means the operand was a perfect square.
            always_ff @(posedge clk) begin
                if (vld_in_s) begin
                    exact_r <= (rem_nxt_s == {REM_W{1'b0}});
                end
            end

            assign spare_unused_s = ^{rem_in_s[REM_W-1 -: 2], q_in_s[HALF-1],
                                      x_in_s[ARG_W-3:0]};
`else
            assign spare_unused_s = ^{rem_in_s[REM_W-1 -: 2], q_in_s[HALF-1],
                                      x_in_s[ARG_W-3:0], rem_nxt_s};
`endif
        end
    end

    assign y_vld = g_stage[HALF-1].vld_r;
    assign y     = g_stage[HALF-1].q_r;
`ifdef SQRT_SUM_PIPE_EXACT_EN
    assign y_exact = g_stage[HALF-1].g_last.exact_r;
`endif

endmodule

// File: rtl/sqrt_sum_pipe.sv
// -----------------------------------------------------------------------------
// sqrt_sum_pipe
// res = sum over enabled channels of floor(sqrt(arg_i)), one argument set per
// clock, fixed latency LAT = ARG_W/2 + clog2(N_CH) + 1.
//   root stage : N_CH isqrt_pipe_w, each fed only when its channel is enabled
//   tree       : clog2(N_CH) registered adder levels, odd node registered
//   output     : res / res_tag register (plus res_exact)
// Ports
//   clk  clock
//   rst  synchronous active-low reset; drops every in-flight transaction
//   bus  sqrt_sum_pipe_if.slave (arg_vld/arg/ch_en/arg_tag in,
//        res_vld/res/res_tag out)
// Optional feature: SQRT_SUM_PIPE_EXACT_EN adds bus.res_exact, 1 when every
// enabled channel is a perfect square (1 when no channel is enabled).
// -----------------------------------------------------------------------------
module sqrt_sum_pipe
    import sqrt_sum_pipe_pkg::*;
#(
    parameter int N_CH  = 3,
    parameter int ARG_W = 32,
    parameter int TAG_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    sqrt_sum_pipe_if.slave bus
);
    localparam int HALF  = ARG_W / 2;
    localparam int LEV   = tree_levels_f(N_CH);
    localparam int LAT   = lat_f(N_CH, ARG_W);
    localparam int RES_W = res_w_f(N_CH, ARG_W);

    // Transaction valid is independent of ch_en, so an all-disabled
    // transaction still produces a result strobe (with res = 0).
    logic [LAT-1:0]   txn_vld_r;
    logic [TAG_W-1:0] tag_r  [LAT];
    logic [N_CH-1:0]  en_r   [HALF];
    logic [HALF-1:0]  root_s [N_CH];
    logic [N_CH-1:0]  y_vld_unused_s;
    logic [RES_W-1:0] res_r;
`ifdef SQRT_SUM_PIPE_EXACT_EN
    logic [N_CH-1:0]  root_exact_s;
    logic             exact_r;
`endif

    // Transaction valid shift register, LAT deep.
    always_ff @(posedge clk) begin
        if (!rst) begin
            txn_vld_r <= '0;
        end else begin
            txn_vld_r <= {txn_vld_r[LAT-2:0], bus.arg_vld};
        end
    end

    // Tag travels beside the transaction valid; the last stage is res_tag.
    always_ff @(posedge clk) begin
        if (bus.arg_vld) begin
            tag_r[0] <= bus.arg_tag;
        end
        for (int k = 1; k < LAT; k++) begin
            if (txn_vld_r[k-1]) begin
                tag_r[k] <= tag_r[k-1];
            end
        end
    end

    // Channel mask delayed alongside the root stages, so a disabled channel's
    // stale root register is masked instead of trusting its y_vld.
    always_ff @(posedge clk) begin
        if (bus.arg_vld) begin
            en_r[0] <= bus.ch_en;
        end
        for (int k = 1; k < HALF; k++) begin
            if (txn_vld_r[k-1]) begin
                en_r[k] <= en_r[k-1];
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic x_vld_s;

        assign x_vld_s = bus.arg_vld & bus.ch_en[i];

        isqrt_pipe_w #(
            .ARG_W (ARG_W)
        ) u_isqrt (
            .clk     (clk),
            .rst     (rst),
            .x_vld   (x_vld_s),
            .x       (bus.arg[i*ARG_W +: ARG_W]),
            .y_vld   (y_vld_unused_s[i]),
            .y       (root_s[i])
`ifdef SQRT_SUM_PIPE_EXACT_EN
            ,
            .y_exact (root_exact_s[i])
`endif
        );
    end

    // Level 0 is the combinational masked leaf set; level l >= 1 registers
    // pair sums of level l-1. Nodes are carried at full RES_W; level l only
    // ever occupies its low HALF+l bits, so the sums cannot overflow.
    for (genvar l = 0; l <= LEV; l++) begin : g_lvl
        localparam int NN = level_nodes_f(N_CH, l);
        localparam int PN = level_nodes_f(N_CH, (l > 0) ? (l - 1) : 0);

        for (genvar j = 0; j < NN; j++) begin : g_n
            logic [RES_W-1:0] val_s;
`ifdef SQRT_SUM_PIPE_EXACT_EN
            logic             ex_s;
`endif
            if (l == 0) begin : g_leaf
                assign val_s = en_r[HALF-1][j] ? RES_W'(root_s[j]) : '0;
`ifdef SQRT_SUM_PIPE_EXACT_EN
                assign ex_s  = en_r[HALF-1][j] ? root_exact_s[j] : 1'b1;
`endif
            end else if (2 * j + 1 < PN) begin : g_add
                logic [RES_W-1:0] sum_r;
`ifdef SQRT_SUM_PIPE_EXACT_EN
                logic             ex_r;
`endif
                // Pair sum, loaded only when this level's input is valid.
                always_ff @(posedge clk) begin
                    if (txn_vld_r[HALF+l-2]) begin
                        sum_r <= g_lvl[l-1].g_n[2*j].val_s
                               + g_lvl[l-1].g_n[2*j+1].val_s;
`ifdef SQRT_SUM_PIPE_EXACT_EN
                        ex_r  <= g_lvl[l-1].g_n[2*j].ex_s
                               & g_lvl[l-1].g_n[2*j+1].ex_s;
`endif
                    end
                end
                assign val_s = sum_r;
`ifdef SQRT_SUM_PIPE_EXACT_EN
                assign ex_s  = ex_r;
`endif
            end else begin : g_pass
                logic [RES_W-1:0] sum_r;
`ifdef SQRT_SUM_PIPE_EXACT_EN
                logic             ex_r;
`endif
                // Odd node: registered pass-through to keep levels aligned.
                always_ff @(posedge clk) begin
                    if (txn_vld_r[HALF+l-2]) begin
                        sum_r <= g_lvl[l-1].g_n[2*j].val_s;
`ifdef SQRT_SUM_PIPE_EXACT_EN
                        ex_r  <= g_lvl[l-1].g_n[2*j].ex_s;
`endif
                    end
                end
                assign val_s = sum_r;
`ifdef SQRT_SUM_PIPE_EXACT_EN
                assign ex_s  = ex_r;
`endif
            end
        end
    end

    // Output register; holds its value between results.
    always_ff @(posedge clk) begin
        if (txn_vld_r[LAT-2]) begin
            res_r <= g_lvl[LEV].g_n[0].val_s;
        end
    end

`ifdef SQRT_SUM_PIPE_EXACT_EN
    // Exactness flag, cleared by reset and loaded with each result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            exact_r <= 1'b0;
        end else if (txn_vld_r[LAT-2]) begin
            exact_r <= g_lvl[LEV].g_n[0].ex_s;
        end
    end

    assign bus.res_exact = exact_r;
`endif

    assign bus.res_vld = txn_vld_r[LAT-1];
    assign bus.res     = res_r;
    assign bus.res_tag = tag_r[LAT-1];

endmodule
